expand_seq: RTL

//  Sequences the feistel block through the Blowfish/bcrypt ExpandState encryption chain.

---
 rtl/expand_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/expand_seq.sv
// expand_seq: drives one feistel instance through the 521-block bcrypt ExpandState chain.
// Blocks 0..8 are written to the P-array, blocks 9..520 to the S-boxes. Each block is
// launched with the running L/R (optionally XORed with half of the salt), the result is
// captured as the new chain value and written to SRAM A (L) and SRAM B (R) in one cycle.
//
// Ports:
//   clk, reset_l            clock, synchronous active-low reset
//   start, salt_en, salt    run request (accepted in idle only), salt controls
//   busy, done, blk_idx     run status, completion pulse, block in flight
//   fs_start, fs_L, fs_R    feistel launch pulse and inputs (held until next launch)
//   fs_resultL/R, fs_done   feistel results and completion pulse
//   fs_addr/cs/we/oe_{a,b}  feistel SRAM traffic, passed through outside write-back
//   sram_*_{a,b}            SRAM ports A/B; controls active low
module expand_seq #(
  parameter int unsigned P_BASE = 4000,
  parameter int unsigned S_BASE = 0,
  parameter int unsigned NBLK   = 521
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  input  logic         salt_en,
  input  logic [127:0] salt,
  output logic         busy,
  output logic         done,
  output logic [9:0]   blk_idx,
  output logic         fs_start,
  output logic [31:0]  fs_L,
  output logic [31:0]  fs_R,
  input  logic [31:0]  fs_resultL,
  input  logic [31:0]  fs_resultR,
  input  logic         fs_done,
  input  logic [11:0]  fs_addr_a,
  input  logic [11:0]  fs_addr_b,
  input  logic         fs_cs_a_l,
  input  logic         fs_cs_b_l,
  input  logic         fs_we_a_l,
  input  logic         fs_we_b_l,
  input  logic         fs_oe_a_l,
  input  logic         fs_oe_b_l,
  output logic [11:0]  sram_addr_a,
  output logic [11:0]  sram_addr_b,
  output logic [31:0]  sram_wdata_a,
  output logic [31:0]  sram_wdata_b,
  output logic         sram_cs_a_l,
  output logic         sram_cs_b_l,
  output logic         sram_we_a_l,
  output logic         sram_we_b_l,
  output logic         sram_oe_a_l,
  output logic         sram_oe_b_l
);

  localparam logic [11:0] PBase   = 12'(P_BASE);
  localparam logic [11:0] SBase   = 12'(S_BASE);
  localparam logic [9:0]  LastIdx = 10'(NBLK - 1);
  // Number of P-array blocks; the S-box region starts at block NumPBlk.
  localparam logic [9:0]  NumPBlk = 10'd9;

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitF, StWrite, StDone} state_e;

  state_e         state_q;
  logic           busy_q;
  logic           done_q;
  logic           fs_start_q;
  logic [9:0]     blk_idx_q;
  logic [31:0]    l_q;
  logic [31:0]    r_q;
  logic [31:0]    fs_l_q;
  logic [31:0]    fs_r_q;
  logic [127:0]   salt_q;
  logic           salt_en_q;

  logic [9:0]     nxt_idx;
  logic [63:0]    launch_sh;
  logic           launch_en;
  logic [31:0]    launch_l;
  logic [31:0]    launch_r;
  logic [11:0]    blk_x2;
  logic [11:0]    wr_addr_a;
  logic [11:0]    wr_addr_b;

  assign nxt_idx = blk_idx_q + 10'd1;

  // Chain input for the next launch. From idle the salt comes straight off the ports
  // (it is being latched this same cycle) and the chain is zero; block 0 is even.
  always_comb begin
    launch_sh = '0;
    launch_en = 1'b0;
    launch_l  = '0;
    launch_r  = '0;
    if (state_q == StIdle) begin
      launch_sh = salt[127:64];
      launch_en = salt_en;
      launch_l  = launch_en ? launch_sh[63:32] : 32'd0;
      launch_r  = launch_en ? launch_sh[31:0]  : 32'd0;
    end else begin
      launch_sh = nxt_idx[0] ? salt_q[63:0] : salt_q[127:64];
      launch_en = salt_en_q;
      launch_l  = l_q ^ (launch_en ? launch_sh[63:32] : 32'd0);
      launch_r  = r_q ^ (launch_en ? launch_sh[31:0]  : 32'd0);
    end
  end

  // Each block covers two consecutive words; S-box offset restarts at zero at block 9.
  assign blk_x2    = {1'b0, blk_idx_q, 1'b0};
  assign wr_addr_a = (blk_idx_q < NumPBlk) ? (PBase + blk_x2) : (SBase + blk_x2 - 12'd18);
  assign wr_addr_b = wr_addr_a + 12'd1;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fs_start_q <= 1'b0;
      blk_idx_q  <= '0;
      l_q        <= '0;
      r_q        <= '0;
      fs_l_q     <= '0;
      fs_r_q     <= '0;
      salt_q     <= '0;
      salt_en_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            salt_q     <= salt;
            salt_en_q  <= salt_en;
            l_q        <= '0;
            r_q        <= '0;
            blk_idx_q  <= '0;
            fs_l_q     <= launch_l;
            fs_r_q     <= launch_r;
            fs_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          // A stray fs_done in this cycle is deliberately not looked at.
          fs_start_q <= 1'b0;
          state_q    <= StWaitF;
        end
        StWaitF: begin
          if (fs_done) begin
            l_q     <= fs_resultL;
            r_q     <= fs_resultR;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (blk_idx_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            blk_idx_q  <= nxt_idx;
            fs_l_q     <= launch_l;
            fs_r_q     <= launch_r;
            fs_start_q <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // SRAM ports belong to the controller only during write-back.
  always_comb begin
    sram_addr_a  = fs_addr_a;
    sram_addr_b  = fs_addr_b;
    sram_wdata_a = '0;
    sram_wdata_b = '0;
    sram_cs_a_l  = fs_cs_a_l;
    sram_cs_b_l  = fs_cs_b_l;
    sram_we_a_l  = fs_we_a_l;
    sram_we_b_l  = fs_we_b_l;
    sram_oe_a_l  = fs_oe_a_l;
    sram_oe_b_l  = fs_oe_b_l;
    if (state_q == StWrite) begin
      sram_addr_a  = wr_addr_a;
      sram_addr_b  = wr_addr_b;
      sram_wdata_a = l_q;
      sram_wdata_b = r_q;
      sram_cs_a_l  = 1'b0;
      sram_cs_b_l  = 1'b0;
      sram_we_a_l  = 1'b0;
      sram_we_b_l  = 1'b0;
      sram_oe_a_l  = 1'b1;
      sram_oe_b_l  = 1'b1;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign blk_idx  = blk_idx_q;
  assign fs_start = fs_start_q;
  assign fs_L     = fs_l_q;
  assign fs_R     = fs_r_q;

endmodule
